clock_time_counter: RTL

- Downstream consumer of the fractional divider's 1-sysclk overflow pulse. With the divider loaded for 1 Hz, each pulse advances a BCD time-of-day register (HH:MM:SS, 24 h).
- Provides synchronous set inputs for hours and minutes, driven by debounced button pulses from the UI block.
- Outputs feed the display/segment driver.
- Emits registered carry pulses for downstream alarm/chime logic.

---
 rtl/clock_pkg.sv | 20 ++
 rtl/bcd_mod_counter.sv | 60 ++++++
 rtl/clock_time_counter.sv | 96 +++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared widths, moduli and reset-value conversion for the BCD time-of-day counter.
package clock_pkg;

  localparam int unsigned HOURS_W  = 6;
  localparam int unsigned MIN_W    = 7;
  localparam int unsigned SEC_W    = 7;
  localparam int unsigned DIGIT_W  = 4;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  // Two-digit packed BCD {tens, ones}; values above 99 are reduced modulo 100.
  function automatic logic [7:0] bin_to_bcd(input int unsigned value);
    int unsigned v;
    v = value % 100;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with increment, synchronous clear and a wrap flag.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned      Width                = 7,
  parameter int unsigned      MAX_TENS             = 5,
  parameter int unsigned      MAX_ONES_AT_MAX_TENS = 9,
  parameter logic [Width-1:0] ResetVal             = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [Width-1:0] value_o,
  output logic             wrap_o
);

  localparam int unsigned        TensW    = Width - DIGIT_W;
  localparam logic [TensW-1:0]   TensMax  = TensW'(MAX_TENS);
  localparam logic [DIGIT_W-1:0] OnesMax  = DIGIT_W'(MAX_ONES_AT_MAX_TENS);
  localparam logic [DIGIT_W-1:0] OnesNine = DIGIT_W'(9);

  logic [Width-1:0]   value_q, value_d;
  logic [TensW-1:0]   tens;
  logic [DIGIT_W-1:0] ones;
  logic               at_terminal;

  assign tens = value_q[Width-1:DIGIT_W];
  assign ones = value_q[DIGIT_W-1:0];

  // Anything at or beyond the terminal value (including corrupted states) wraps to zero.
  assign at_terminal = (tens > TensMax) || ((tens == TensMax) && (ones >= OnesMax));
  assign wrap_o      = inc_i && at_terminal;

  always_comb begin
    value_d = value_q;
    if (clear_i) begin
      value_d = '0;
    end else if (inc_i) begin
      if (at_terminal) begin
        value_d = '0;
      end else if (ones >= OnesNine) begin
        value_d = {tens + TensW'(1), {DIGIT_W{1'b0}}};
      end else begin
        value_d = {tens, ones + DIGIT_W'(1)};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= ResetVal;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/clock_time_counter.sv
// 24-hour BCD HH:MM:SS counter advanced by divider ticks, with set buttons and carry pulses.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned RESET_HOURS   = 0,
  parameter int unsigned RESET_MINUTES = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic               i_tick,
  input  logic               i_set_hours,
  input  logic               i_set_minutes,
  output logic [HOURS_W-1:0] o_hours,
  output logic [MIN_W-1:0]   o_minutes,
  output logic [SEC_W-1:0]   o_seconds,
  output logic               o_min_pulse,
  output logic               o_day_pulse
);

  localparam logic [HOURS_W-1:0] ResetHoursBcd = HOURS_W'(bin_to_bcd(RESET_HOURS));
  localparam logic [MIN_W-1:0]   ResetMinBcd   = MIN_W'(bin_to_bcd(RESET_MINUTES));

  logic tick_ok;
  logic sec_inc, min_inc, hour_inc;
  logic sec_wrap, min_wrap, hour_wrap;
  logic min_pulse_q, min_pulse_d;
  logic day_pulse_q, day_pulse_d;

  // Any set pulse swallows a coincident tick, so set and carry never interact.
  assign tick_ok  = i_en && i_tick && !i_set_hours && !i_set_minutes;
  assign sec_inc  = tick_ok;
  assign min_inc  = (tick_ok && sec_wrap) || i_set_minutes;
  assign hour_inc = (tick_ok && sec_wrap && min_wrap) || i_set_hours;

  bcd_mod_counter #(
    .Width               (SEC_W),
    .MAX_TENS            (SEC_MAX / 10),
    .MAX_ONES_AT_MAX_TENS(SEC_MAX % 10),
    .ResetVal            ('0)
  ) u_seconds (
    .clk_i  (i_clk),
    .rst_i  (i_reset),
    .inc_i  (sec_inc),
    .clear_i(i_set_minutes),
    .value_o(o_seconds),
    .wrap_o (sec_wrap)
  );

  bcd_mod_counter #(
    .Width               (MIN_W),
    .MAX_TENS            (MIN_MAX / 10),
    .MAX_ONES_AT_MAX_TENS(MIN_MAX % 10),
    .ResetVal            (ResetMinBcd)
  ) u_minutes (
    .clk_i  (i_clk),
    .rst_i  (i_reset),
    .inc_i  (min_inc),
    .clear_i(1'b0),
    .value_o(o_minutes),
    .wrap_o (min_wrap)
  );

  bcd_mod_counter #(
    .Width               (HOURS_W),
    .MAX_TENS            (HOUR_MAX / 10),
    .MAX_ONES_AT_MAX_TENS(HOUR_MAX % 10),
    .ResetVal            (ResetHoursBcd)
  ) u_hours (
    .clk_i  (i_clk),
    .rst_i  (i_reset),
    .inc_i  (hour_inc),
    .clear_i(1'b0),
    .value_o(o_hours),
    .wrap_o (hour_wrap)
  );

  always_comb begin
    min_pulse_d = sec_wrap;
    day_pulse_d = sec_wrap && min_wrap && hour_wrap;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      min_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      min_pulse_q <= min_pulse_d;
      day_pulse_q <= day_pulse_d;
    end
  end

  assign o_min_pulse = min_pulse_q;
  assign o_day_pulse = day_pulse_q;

endmodule
